seq_detect_prog: RTL and testbench
==================================

# seq_detect_prog

Programmable serial bit-pattern detector, successor to the fixed 5-bit non-overlapping detector FSM. Pattern, pattern length (1..MAX_LEN) and overlap mode are loaded at run time, not hard-wired. Input bits are qualified by a valid strobe. A registered one-cycle `flag` pulse marks every completed match. Sits on serial control/framing paths wherever a sync word or marker must be found.

## Interface
- `MAX_LEN`, default 8: maximum pattern length in bits, ≥2.
- `CNT_W`, default 8: hit counter width. Only used with `SEQ_DET_CNT_EN`.
- `LEN_W`, derived, `$clog2(MAX_LEN+1)`: width of `cfg_len`.
- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: reset; asynchronous, active-low.
- `cfg_load`, in, 1: one-cycle strobe; latches `cfg_pattern`, `cfg_len` and `cfg_overlap`.
- `cfg_pattern`, in, MAX_LEN: pattern. Bit `[cfg_len-1]` is the first bit received, bit `[0]` the last.
- `cfg_len`, in, LEN_W: pattern length.
- `cfg_overlap`, in, 1: 1 = overlapping detection, 0 = non-overlapping.
- `data_vld`, in, 1: `data` is valid this cycle.
- `data`, in, 1: serial input bit.
- `flag`, out, 1: registered match pulse.
- `cfg_err`, out, 1: the latched `cfg_len` is 0 or greater than MAX_LEN. Detection is disabled while this is high.
- `hit_cnt`, out, CNT_W: saturating match count. Present only with `SEQ_DET_CNT_EN`.

## Operation
- **State machine:** UNCFG, FILL, ARMED.
- **Reset values:**
  - state = UNCFG.
  - Pattern, length, overlap registers, history and fill counter are all 0.
  - `flag` = 0, `cfg_err` = 0, `hit_cnt` = 0.
- **Configuration load (`cfg_load` = 1):**
  - Any state goes to FILL.
  - Latches the config and clears history and fill.
  - `data` in that same cycle is ignored.
  - If the latched length is invalid, the state goes to UNCFG instead and `cfg_err` = 1.
- **UNCFG:** ignores `data` and never flags.
- **Bit acceptance:** each cycle with `data_vld` = 1, in FILL or ARMED:
  - history shifts left and takes `data` into bit 0;
  - fill = min(fill+1, len).
- **FILL → ARMED:** when the new fill equals len.
- **Match:** new fill = len and the low `len` bits of the new history equal the low `len` bits of the pattern. Pattern bits above `len` are don't-care.
- **On match:**
  - `flag` <= 1 on the next edge.
  - Overlap mode: history is kept and the state stays ARMED.
  - Non-overlap mode: fill <= 0 and the state goes to FILL.
- **`flag` clearing:** `flag` <= 0 in every cycle without a match, including cycles with `data_vld` = 0.
- **`cfg_load` and match in the same cycle:** `cfg_load` wins. No flag and no count.
- **`cfg_len` = 1:** every accepted bit equal to `pattern[0]` flags, in either mode.

## Timing
- **Latency:** `flag` rises in the cycle after the edge that samples the final pattern bit, and is high for exactly one cycle per match.
- **Back-to-back matches:** in overlap mode `flag` may stay high on consecutive cycles (e.g. pattern 11 on a stream of 1s).
- **Gaps:** `data_vld` gaps stall detection without losing history.
- **Config timing:** `cfg_err` updates on the edge after `cfg_load`. The new config applies to the first valid bit after the load cycle.
- **Reset mid-operation:** asynchronous. All outputs drop immediately and partial matches are discarded.

## Configuration
- Macro: `SEQ_DET_CNT_EN`.
- **Defined:**
  - `hit_cnt` exists and increments by 1 on each match, in the same edge that sets `flag`.
  - It saturates at 2^CNT_W−1.
  - It is cleared by reset and by `cfg_load`.
- **Undefined:** the port and the counter logic are absent. All other behaviour is identical.

## Structure
- **Package `seq_det_pkg`:** state enum (UNCFG, FILL, ARMED) and an `LEN_W` helper function.
- **Sub-module `seq_det_hist`:**
  - holds the history shift register and the saturating fill counter;
  - clear and shift inputs;
  - outputs history and `full` (fill == len).
- **Top module:** FSM, masked compare, flag register and optional counter.

## Test plan
- **Non-overlap, 10111:** pattern 10111, len 5, `cfg_overlap` = 0, stream 1011110111 -> `flag` pulses after bits 5 and 10 only.
- **Pattern 11, both modes:** stream 1111 -> overlap flags after bits 2, 3, 4; non-overlap flags after bits 2 and 4.
- **Valid gaps:** same as the first scenario with `data_vld` low for 3 cycles between bits 3 and 4 -> identical flags; `flag` never high on the cycle after a `data_vld` = 0 cycle.
- **Invalid length:** `cfg_len` = 0, then 9 with MAX_LEN = 8 -> `cfg_err` = 1, no flags; reload with len 3 -> `cfg_err` = 0 and detection resumes.
- **Reset mid-match:** pattern 10111, feed 1011, assert `rst`, release, feed 1 -> `flag` stays 0 and the state is UNCFG.
- **Counter saturation:** `SEQ_DET_CNT_EN` defined, CNT_W = 2, 5 matches -> `hit_cnt` reads 1, 2, 3, 3, 3; `cfg_load` clears it to 0.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types for the programmable sequence detector: FSM state encoding
// and the cfg_len width helper.
package seq_det_pkg;

  typedef enum logic [1:0] {
    ST_UNCFG = 2'd0,
    ST_FILL  = 2'd1,
    ST_ARMED = 2'd2
  } state_t;

  function automatic int calc_len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/seq_det_hist.sv
// History shift register plus fill counter saturating at the pattern length.
// Exposes the post-shift history/full view so a match can be judged in the accepting cycle.
module seq_det_hist #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clr,
  input  logic               i_drop,
  input  logic               i_shift,
  input  logic               i_bit,
  input  logic [LEN_W-1:0]   i_len,
  output logic [MAX_LEN-1:0] o_hist_nxt,
  output logic               o_full_nxt
);

  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic [LEN_W-1:0]   w_fill_inc;

  assign o_hist_nxt = {r_hist[MAX_LEN-2:0], i_bit};
  // fill never exceeds len, so the increment cannot wrap
  assign w_fill_inc = (r_fill >= i_len) ? i_len : r_fill + 1'b1;
  assign o_full_nxt = (w_fill_inc == i_len);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (i_clr) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (i_shift) begin
      r_hist <= o_hist_nxt;
      r_fill <= i_drop ? '0 : w_fill_inc;
    end
  end

endmodule

// File: rtl/seq_detect_prog.sv
// Programmable serial pattern detector (run-time pattern, length, overlap).
// Optional saturating hit counter enabled by `define SEQ_DET_CNT_EN.
module seq_detect_prog
  import seq_det_pkg::*;
#(
  parameter  int MAX_LEN = 8,
  parameter  int CNT_W   = 8,
  localparam int LEN_W   = calc_len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               data_vld,
  input  logic               data,
  output logic               flag,
  output logic               cfg_err
`ifdef SEQ_DET_CNT_EN
  ,
  output logic [CNT_W-1:0]   hit_cnt
`endif
);

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  if (MAX_LEN < 2 || CNT_W < 1) begin : g_bad_param
    $error("seq_detect_prog: MAX_LEN must be >= 2 and CNT_W >= 1");
  end

  state_t             r_state, w_state_nxt;
  logic [MAX_LEN-1:0] r_pattern;
  logic [LEN_W-1:0]   r_len;
  logic               r_overlap;
  logic               r_flag;
  logic               r_cfg_err;

  logic               w_cfg_bad;
  logic               w_shift;
  logic               w_match;
  logic               w_flag_nxt;
  logic [MAX_LEN-1:0] w_mask;
  logic [MAX_LEN-1:0] w_hist_nxt;
  logic               w_full_nxt;

  assign w_cfg_bad = (cfg_len == '0) || (cfg_len > MAX_LEN_L);
  // cfg_load in the same cycle discards the data bit and any pending match
  assign w_shift   = (r_state != ST_UNCFG) && data_vld && !cfg_load;

  for (genvar i = 0; i < MAX_LEN; i++) begin : g_mask
    assign w_mask[i] = (LEN_W'(i) < r_len);
  end

  seq_det_hist #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_hist (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (cfg_load),
    .i_drop     (w_match && !r_overlap),
    .i_shift    (w_shift),
    .i_bit      (data),
    .i_len      (r_len),
    .o_hist_nxt (w_hist_nxt),
    .o_full_nxt (w_full_nxt)
  );

  assign w_match = w_shift && w_full_nxt && (((w_hist_nxt ^ r_pattern) & w_mask) == '0);

  always_comb begin
    w_state_nxt = r_state;
    w_flag_nxt  = 1'b0;
    if (cfg_load) begin
      w_state_nxt = w_cfg_bad ? ST_UNCFG : ST_FILL;
    end else if (w_shift) begin
      w_flag_nxt = w_match;
      if (w_match && !r_overlap) w_state_nxt = ST_FILL;
      else if (w_full_nxt)       w_state_nxt = ST_ARMED;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_UNCFG;
      r_pattern <= '0;
      r_len     <= '0;
      r_overlap <= 1'b0;
      r_flag    <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_flag  <= w_flag_nxt;
      if (cfg_load) begin
        r_pattern <= cfg_pattern;
        r_len     <= cfg_len;
        r_overlap <= cfg_overlap;
        r_cfg_err <= w_cfg_bad;
      end
    end
  end

  assign flag    = r_flag;
  assign cfg_err = r_cfg_err;

`ifdef SEQ_DET_CNT_EN
  logic [CNT_W-1:0] r_hit_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                              r_hit_cnt <= '0;
    else if (cfg_load)                     r_hit_cnt <= '0;
    else if (w_match && (r_hit_cnt != '1)) r_hit_cnt <= r_hit_cnt + 1'b1;
  end

  assign hit_cnt = r_hit_cnt;
`endif

endmodule

// File: tb/tb_seq_detect_prog.sv
// Self-checking bench for seq_detect_prog: directed scenarios plus randomized
// traffic against a queue-based reference model of the matching rules.
`timescale 1ns/1ps
module tb_seq_detect_prog;

  localparam int MAX_LEN = 8;
`ifdef SEQ_DET_CNT_EN
  localparam int CNT_W = 2;
`else
  localparam int CNT_W = 8;
`endif
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               cfg_load = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic               cfg_overlap = 1'b0;
  logic               data_vld = 1'b0;
  logic               data = 1'b0;
  logic               flag;
  logic               cfg_err;
`ifdef SEQ_DET_CNT_EN
  logic [CNT_W-1:0]   hit_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // reference model state: bits accepted since the last load / non-overlap match
  bit                 m_cfg;
  bit                 m_err;
  bit                 m_flag;
  bit                 m_ov;
  int                 m_len;
  logic [MAX_LEN-1:0] m_pat;
  int                 m_cnt;
  bit                 q[$];

  seq_detect_prog #(
    .MAX_LEN (MAX_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .data_vld    (data_vld),
    .data        (data),
    .flag        (flag),
    .cfg_err     (cfg_err)
`ifdef SEQ_DET_CNT_EN
    ,
    .hit_cnt     (hit_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit ld, input logic [MAX_LEN-1:0] pat, input int len,
                            input bit ov, input bit vld, input bit d);
    bit hit;
    m_flag = 1'b0;
    if (ld) begin
      m_pat = pat; m_len = len; m_ov = ov;
      m_err = (len == 0) || (len > MAX_LEN);
      m_cfg = !m_err;
      m_cnt = 0;
      q.delete();
    end else if (m_cfg && vld) begin
      q.push_back(d);
      if (q.size() > MAX_LEN) void'(q.pop_front());
      if (q.size() >= m_len) begin
        hit = 1'b1;
        for (int k = 0; k < m_len; k++)
          if (q[q.size() - 1 - k] != m_pat[k]) hit = 1'b0;
        if (hit) begin
          m_flag = 1'b1;
          if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
          if (!m_ov) q.delete();
        end
      end
    end
  endtask

  task automatic cyc(input bit ld, input logic [MAX_LEN-1:0] pat, input int len,
                     input bit ov, input bit vld, input bit d);
    cfg_load = ld; cfg_pattern = pat; cfg_len = LEN_W'(len); cfg_overlap = ov;
    data_vld = vld; data = d;
    @(posedge clk);
    model_step(ld, pat, len, ov, vld, d);
    #1;
    chk("flag", flag, m_flag);
    chk("cfg_err", cfg_err, m_err);
`ifdef SEQ_DET_CNT_EN
    chk("hit_cnt", hit_cnt, m_cnt);
`endif
    cfg_load = 1'b0; data_vld = 1'b0;
  endtask

  task automatic load(input logic [MAX_LEN-1:0] pat, input int len, input bit ov);
    cyc(1'b1, pat, len, ov, 1'b1, 1'b1);
  endtask

  // feed n bits MSB first; expf holds the independently derived flag per bit
  task automatic feed(input int n, input logic [31:0] bits, input logic [31:0] expf);
    for (int i = n - 1; i >= 0; i--) begin
      cyc(1'b0, m_pat, m_len, m_ov, 1'b1, bits[i]);
      chk("dir_flag", flag, expf[i]);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    m_cfg = 0; m_err = 0; m_flag = 0; m_cnt = 0; m_ov = 0; m_len = 0; m_pat = '0;
    q.delete();
    chk("rst_flag", flag, 0);
    chk("rst_cfg_err", cfg_err, 0);
`ifdef SEQ_DET_CNT_EN
    chk("rst_hit_cnt", hit_cnt, 0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    logic [MAX_LEN-1:0] rp;
    int                 rl;
    #1;
    do_reset();

    // non-overlap 10111
    load(8'b10111, 5, 1'b0);
    chk("cfg_err_ok", cfg_err, 0);
    feed(10, 32'b1011110111, 32'b0000100001);

    // pattern 11 both modes
    load(8'b11, 2, 1'b1);
    feed(4, 32'b1111, 32'b0111);
    load(8'b11, 2, 1'b0);
    feed(4, 32'b1111, 32'b0101);

    // valid gaps
    load(8'b10111, 5, 1'b0);
    feed(3, 32'b101, 32'b000);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, m_pat, m_len, m_ov, 1'b0, 1'b1);
      chk("gap_flag", flag, 0);
    end
    feed(7, 32'b1110111, 32'b0100001);

    // invalid lengths, then recovery
    load(8'hFF, 0, 1'b1);
    chk("cfg_err_len0", cfg_err, 1);
    feed(8, 32'hFF, 32'h0);
    load(8'hFF, 9, 1'b1);
    chk("cfg_err_len9", cfg_err, 1);
    feed(8, 32'hFF, 32'h0);
    load(8'b101, 3, 1'b1);
    chk("cfg_err_clr", cfg_err, 0);
    feed(5, 32'b10101, 32'b00101);

    // reset mid-match, and async drop of a live flag
    load(8'b10111, 5, 1'b0);
    feed(4, 32'b1011, 32'b0000);
    do_reset();
    feed(1, 32'b1, 32'b0);
    feed(5, 32'b10111, 32'b00000);
    load(8'b11, 2, 1'b1);
    feed(2, 32'b11, 32'b01);
    do_reset();

`ifdef SEQ_DET_CNT_EN
    load(8'b1, 1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, m_pat, m_len, m_ov, 1'b1, 1'b1);
      chk("sat_cnt", hit_cnt, (i < 3) ? i + 1 : 3);
    end
    load(8'b1, 1, 1'b0);
    chk("cnt_clr", hit_cnt, 0);
`endif

    // randomized traffic
    for (int r = 0; r < 24; r++) begin
      if (r % 8 == 5) do_reset();
      rp = MAX_LEN'($urandom);
      rl = ($urandom_range(0, 9) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : 9)
                                       : $urandom_range(1, 5);
      load(rp, rl, 1'($urandom_range(0, 1)));
      for (int c = 0; c < 80; c++) begin
        if ($urandom_range(0, 49) == 0)
          cyc(1'b1, MAX_LEN'($urandom), $urandom_range(1, 4), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        else
          cyc(1'b0, m_pat, m_len, m_ov, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
